// File: rtl/nf10_param_output_port_lookup.sv
// Output-port lookup: small fall-through input FIFO, header-beat dst rewrite
// (NIC / flood / fixed / drop), silent discard of undeliverable packets, saturating stats.
module nf10_param_output_port_lookup #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4,
  parameter int SRC_PORT_POS       = 16,
  parameter int DST_PORT_POS       = 32,
  parameter int FIFO_DEPTH_BITS    = 2,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic [1:0]                      mode,
  input  logic [2*NUM_PORTS-1:0]          fixed_dst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            S_AXIS_TLAST,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic [CNT_WIDTH-1:0]            pkt_fwd_count,
  output logic [CNT_WIDTH-1:0]            pkt_drop_count
);

  localparam int PW    = 2 * NUM_PORTS;
  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int SW    = C_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int OW    = FIFO_DEPTH_BITS + 1;

  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = FIFO_DEPTH_BITS'(1);
  localparam logic [OW-1:0]              OCC_ONE = OW'(1);
  localparam logic [OW-1:0]              OCC_LIM = OW'(DEPTH - 1);
  localparam logic [PW-1:0]              PW_ONE  = PW'(1);
  localparam logic [CNT_WIDTH-1:0]       CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [PW-1:0] even_mask();
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < PW; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [PW-1:0] PM = even_mask();

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] data_mem [DEPTH];
  logic [SW-1:0] strb_mem [DEPTH];
  logic [UW-1:0] user_mem [DEPTH];
  logic          last_mem [DEPTH];

  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]              occ_q;
  logic [CNT_WIDTH-1:0]       fwd_cnt_q, drop_cnt_q;

  logic          empty, s_ready, wr_en, rd_en, m_valid;
  logic [DW-1:0] head_data;
  logic [SW-1:0] head_strb;
  logic [UW-1:0] head_user, out_user;
  logic          head_last;
  logic [PW-1:0] src, dst;
  logic          src_onehot, from_cpu, hdr_drop, fwd_inc, drop_inc;

  // Handshake: a beat moves on either side only in a cycle where valid and ready are both high.
  assign empty   = (occ_q == '0);
  assign s_ready = !AXI_RESET && (occ_q < OCC_LIM);
  assign wr_en   = S_AXIS_TVALID && s_ready;

  assign head_data = data_mem[rd_ptr_q];
  assign head_strb = strb_mem[rd_ptr_q];
  assign head_user = user_mem[rd_ptr_q];
  assign head_last = last_mem[rd_ptr_q];

  always_comb begin
    src        = head_user[SRC_PORT_POS +: PW];
    src_onehot = (src != '0) && ((src & (src - PW_ONE)) == '0);
    from_cpu   = |(src & ~PM);
    dst        = '0;
    case (mode)
      2'd0:    dst = from_cpu ? (src >> 1) : (src << 1);
      2'd1:    dst = from_cpu ? PM : (PM & ~src);
      2'd2:    dst = fixed_dst;
      default: dst = '0;
    endcase
    hdr_drop = !src_onehot || (mode == 2'd3) || (dst == '0);
  end

  always_comb begin
    state_d  = state_q;
    m_valid  = 1'b0;
    rd_en    = 1'b0;
    out_user = head_user;
    case (state_q)
      ST_HEADER: begin
        if (hdr_drop) begin
          rd_en = !empty;
        end else begin
          m_valid = !empty;
          rd_en   = !empty && M_AXIS_TREADY;
          out_user[DST_PORT_POS +: PW] = dst;
        end
        if (rd_en && !head_last) state_d = hdr_drop ? ST_DROP : ST_FORWARD;
      end
      ST_FORWARD: begin
        m_valid = !empty;
        rd_en   = !empty && M_AXIS_TREADY;
        if (rd_en && head_last) state_d = ST_HEADER;
      end
      ST_DROP: begin
        rd_en = !empty;
        if (rd_en && head_last) state_d = ST_HEADER;
      end
      default: state_d = ST_HEADER;
    endcase
  end

  assign fwd_inc  = (state_q == ST_HEADER) && rd_en && !hdr_drop;
  assign drop_inc = (state_q == ST_HEADER) && rd_en && hdr_drop;

  // Storage has no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) begin
      data_mem[wr_ptr_q] <= S_AXIS_TDATA;
      strb_mem[wr_ptr_q] <= S_AXIS_TSTRB;
      user_mem[wr_ptr_q] <= S_AXIS_TUSER;
      last_mem[wr_ptr_q] <= S_AXIS_TLAST;
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      state_q    <= ST_HEADER;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
      state_q <= state_d;
      if (fwd_inc && (fwd_cnt_q != '1))   fwd_cnt_q  <= fwd_cnt_q + CNT_ONE;
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_ONE;
    end
  end

  assign S_AXIS_TREADY  = s_ready;
  assign M_AXIS_TVALID  = m_valid;
  assign M_AXIS_TDATA   = head_data;
  assign M_AXIS_TSTRB   = head_strb;
  assign M_AXIS_TUSER   = out_user;
  assign M_AXIS_TLAST   = head_last;
  assign pkt_fwd_count  = fwd_cnt_q;
  assign pkt_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_nf10_param_output_port_lookup.sv
// Bench for nf10_param_output_port_lookup: scenario tasks feed packets, a negedge
// monitor pops the expected-beat queue on every egress handshake.
module tb_nf10_param_output_port_lookup;

  localparam int DW      = 256;
  localparam int SW      = DW / 8;
  localparam int UW      = 128;
  localparam int NP      = 4;
  localparam int PW      = 2 * NP;
  localparam int SRC_POS = 16;
  localparam int DST_POS = 32;
  localparam int CW      = 32;
  localparam int EW      = UW + DW + SW + 1;

  logic          clk;
  logic          AXI_RESET;
  logic [1:0]    mode;
  logic [PW-1:0] fixed_dst;
  logic [DW-1:0] S_AXIS_TDATA;
  logic [SW-1:0] S_AXIS_TSTRB;
  logic [UW-1:0] S_AXIS_TUSER;
  logic          S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [SW-1:0] M_AXIS_TSTRB;
  logic [UW-1:0] M_AXIS_TUSER;
  logic          M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [CW-1:0] pkt_fwd_count, pkt_drop_count;

  nf10_param_output_port_lookup #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(NP),
    .SRC_PORT_POS(SRC_POS), .DST_PORT_POS(DST_POS), .FIFO_DEPTH_BITS(2), .CNT_WIDTH(CW)
  ) dut (
    .AXI_ACLK(clk), .AXI_RESET(AXI_RESET), .mode(mode), .fixed_dst(fixed_dst),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .pkt_fwd_count(pkt_fwd_count), .pkt_drop_count(pkt_drop_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_beat, exp_beat;
  int            beats_seen = 0;
  bit            saw_tvalid = 1'b0;
  logic [CW-1:0] exp_fwd = '0;
  logic [CW-1:0] exp_drop = '0;

  // Scoreboard: every egress handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!AXI_RESET) begin
      if (M_AXIS_TVALID) saw_tvalid = 1'b1;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beats_seen++;
        got_beat = {M_AXIS_TUSER, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got tuser=%h last=%b, expected no beat", M_AXIS_TUSER, M_AXIS_TLAST);
        end else begin
          exp_beat = exp_q.pop_front();
          if (got_beat !== exp_beat) begin
            errors++;
            $display("FAIL beat: got %h expected %h", got_beat, exp_beat);
          end
        end
      end
    end
  end

  // Reference routing: returns {drop, dst}, computed from the port index of src.
  function automatic logic [PW:0] model_route(input logic [1:0] md, input logic [PW-1:0] s,
                                              input logic [PW-1:0] fx);
    int ones = 0;
    int idx = 0;
    logic [PW-1:0] d = '0;
    for (int i = 0; i < PW; i++) if (s[i]) begin ones++; idx = i; end
    if (ones != 1 || md == 2'd3) return {1'b1, {PW{1'b0}}};
    case (md)
      2'd0: if (idx % 2 == 0) d[idx + 1] = 1'b1; else d[idx - 1] = 1'b1;
      2'd1: for (int p = 0; p < NP; p++) if (2 * p != idx) d[2 * p] = 1'b1;
      default: d = fx;
    endcase
    return {(d == '0), d};
  endfunction

  // Driver tasks
  task automatic wait_idle();
    int t;
    for (t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic [UW-1:0] u, input logic l);
    bit ok = 1'b0;
    int t;
    S_AXIS_TDATA  = d;
    S_AXIS_TSTRB  = s;
    S_AXIS_TUSER  = u;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    for (t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = S_AXIS_TREADY;
      @(posedge clk);
    end
    #1;
    S_AXIS_TVALID = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ingress_timeout: got S_AXIS_TREADY=0 for 500 cycles, expected 1");
    end
  endtask

  task automatic send_pkt(input logic [PW-1:0] src, input int nbeats, input logic [1:0] md,
                          input logic [PW-1:0] fx, input int sw_beat, input logic [1:0] sw_mode);
    logic [PW:0]   r;
    logic [UW-1:0] u, eu;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
    if (md !== mode || fx !== fixed_dst) begin
      wait_idle();
      mode      = md;
      fixed_dst = fx;
    end
    r = model_route(md, src, fx);
    if (r[PW]) exp_drop++; else exp_fwd++;
    for (int b = 0; b < nbeats; b++) begin
      if (b == sw_beat) mode = sw_mode;
      for (int k = 0; k < UW / 32; k++) u[k*32 +: 32] = $urandom();
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      u[SRC_POS +: PW] = src;
      s  = $urandom();
      l  = (b == nbeats - 1);
      eu = u;
      if (b == 0) eu[DST_POS +: PW] = r[PW-1:0];
      if (!r[PW]) exp_q.push_back({eu, d, s, l});
      send_beat(d, s, u, l);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b expected 0", S_AXIS_TREADY); end
    if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b expected 0", M_AXIS_TVALID); end
    if (pkt_fwd_count !== '0) begin errors++; $display("FAIL rst_fwd: got %0d expected 0", pkt_fwd_count); end
    if (pkt_drop_count !== '0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", pkt_drop_count); end
    @(posedge clk);
    #1;
    AXI_RESET     = 1'b0;
    M_AXIS_TREADY = 1'b1;
    @(negedge clk);
    checks++;
    if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL post_rst_s_tready: got %b expected 1", S_AXIS_TREADY); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nic();
    send_pkt(8'h01, 1, 2'd0, 8'h00, -1, 2'd0);
    send_pkt(8'h08, 1, 2'd0, 8'h00, -1, 2'd0);
    wait_idle();
    checks += 2;
    if (pkt_fwd_count !== 32'd2) begin errors++; $display("FAIL nic_fwd: got %0d expected 2", pkt_fwd_count); end
    if (pkt_drop_count !== 32'd0) begin errors++; $display("FAIL nic_drop: got %0d expected 0", pkt_drop_count); end
  endtask

  task automatic test_flood();
    send_pkt(8'h04, 3, 2'd1, 8'h00, -1, 2'd0);
    send_pkt(8'h02, 2, 2'd1, 8'h00, -1, 2'd0);
    wait_idle();
    checks += 2;
    if (pkt_fwd_count !== exp_fwd) begin errors++; $display("FAIL flood_fwd: got %0d expected %0d", pkt_fwd_count, exp_fwd); end
    if (pkt_drop_count !== exp_drop) begin errors++; $display("FAIL flood_drop: got %0d expected %0d", pkt_drop_count, exp_drop); end
  endtask

  task automatic test_drop();
    wait_idle();
    M_AXIS_TREADY = 1'b0;
    saw_tvalid    = 1'b0;
    send_pkt(8'h01, 3, 2'd2, 8'h00, -1, 2'd0);
    send_pkt(8'h04, 3, 2'd3, 8'h00, -1, 2'd0);
    wait_idle();
    checks += 3;
    if (saw_tvalid !== 1'b0) begin errors++; $display("FAIL drop_tvalid: got 1 expected 0"); end
    if (pkt_fwd_count !== exp_fwd) begin errors++; $display("FAIL drop_fwd: got %0d expected %0d", pkt_fwd_count, exp_fwd); end
    if (pkt_drop_count !== exp_drop) begin errors++; $display("FAIL drop_drop: got %0d expected %0d", pkt_drop_count, exp_drop); end
    M_AXIS_TREADY = 1'b1;
  endtask

  task automatic test_bad_src();
    send_pkt(8'h00, 2, 2'd0, 8'h00, -1, 2'd0);
    send_pkt(8'h03, 1, 2'd0, 8'h00, -1, 2'd0);
    send_pkt(8'h10, 2, 2'd0, 8'h00, -1, 2'd0);
    wait_idle();
    checks += 2;
    if (pkt_fwd_count !== exp_fwd) begin errors++; $display("FAIL badsrc_fwd: got %0d expected %0d", pkt_fwd_count, exp_fwd); end
    if (pkt_drop_count !== exp_drop) begin errors++; $display("FAIL badsrc_drop: got %0d expected %0d", pkt_drop_count, exp_drop); end
  endtask

  task automatic test_backpressure();
    wait_idle();
    M_AXIS_TREADY = 1'b1;
    fork
      send_pkt(8'h01, 5, 2'd0, 8'h00, -1, 2'd0);
      begin
        int start = beats_seen;
        int t;
        for (t = 0; t < 200 && beats_seen == start; t++) @(posedge clk);
        #1;
        M_AXIS_TREADY = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL bp_s_tready: got %b expected 0", S_AXIS_TREADY); end
        if (M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL bp_m_tvalid: got %b expected 1", M_AXIS_TVALID); end
        @(posedge clk);
        #1;
        M_AXIS_TREADY = 1'b1;
      end
    join
    wait_idle();
    checks++;
    if (pkt_fwd_count !== exp_fwd) begin errors++; $display("FAIL bp_fwd: got %0d expected %0d", pkt_fwd_count, exp_fwd); end
  endtask

  task automatic test_mode_switch();
    wait_idle();
    send_pkt(8'h04, 4, 2'd0, 8'h00, 2, 2'd1);
    send_pkt(8'h01, 2, 2'd1, 8'h00, -1, 2'd0);
    wait_idle();
    checks++;
    if (pkt_fwd_count !== exp_fwd) begin errors++; $display("FAIL modesw_fwd: got %0d expected %0d", pkt_fwd_count, exp_fwd); end
  endtask

  task automatic test_reset_mid_pkt();
    logic [UW-1:0] u = '0;
    wait_idle();
    mode          = 2'd0;
    M_AXIS_TREADY = 1'b0;
    u[SRC_POS +: PW] = 8'h01;
    send_beat({8{32'h1234_5678}}, '1, u, 1'b0);
    send_beat({8{32'h9abc_def0}}, '1, u, 1'b0);
    @(posedge clk);
    #3;
    AXI_RESET = 1'b1;
    @(negedge clk);
    checks += 4;
    if (pkt_fwd_count !== '0) begin errors++; $display("FAIL midrst_fwd: got %0d expected 0", pkt_fwd_count); end
    if (pkt_drop_count !== '0) begin errors++; $display("FAIL midrst_drop: got %0d expected 0", pkt_drop_count); end
    if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL midrst_s_tready: got %b expected 0", S_AXIS_TREADY); end
    if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid: got %b expected 0", M_AXIS_TVALID); end
    @(posedge clk);
    #1;
    AXI_RESET     = 1'b0;
    exp_fwd       = '0;
    exp_drop      = '0;
    M_AXIS_TREADY = 1'b1;
    send_pkt(8'h04, 1, 2'd0, 8'h00, -1, 2'd0);
    wait_idle();
    checks += 2;
    if (pkt_fwd_count !== 32'd1) begin errors++; $display("FAIL midrst_after_fwd: got %0d expected 1", pkt_fwd_count); end
    if (pkt_drop_count !== 32'd0) begin errors++; $display("FAIL midrst_after_drop: got %0d expected 0", pkt_drop_count); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] tbl [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h03, 8'h30};
    for (int md = 0; md < 3; md++) begin
      logic [PW-1:0] fx = PW'($urandom_range(1, 255));
      bit done = 1'b0;
      fork
        begin
          for (int n = 0; n < 6; n++)
            send_pkt(tbl[$urandom_range(0, 10)], $urandom_range(1, 4), 2'(md), fx, -1, 2'd0);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            M_AXIS_TREADY = 1'($urandom_range(0, 1));
          end
        end
      join
      M_AXIS_TREADY = 1'b1;
      wait_idle();
    end
    checks += 2;
    if (pkt_fwd_count !== exp_fwd) begin errors++; $display("FAIL b2b_fwd: got %0d expected %0d", pkt_fwd_count, exp_fwd); end
    if (pkt_drop_count !== exp_drop) begin errors++; $display("FAIL b2b_drop: got %0d expected %0d", pkt_drop_count, exp_drop); end
  endtask

  initial begin
    AXI_RESET     = 1'b1;
    mode          = 2'd0;
    fixed_dst     = '0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TSTRB  = '0;
    S_AXIS_TUSER  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b0;
    test_reset();
    test_nic();
    test_flood();
    test_drop();
    test_bad_src();
    test_backpressure();
    test_mode_switch();
    test_reset_mid_pkt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
